// File: rtl/beep_sequencer_pkg.sv
// beep_sequencer_pkg
// Shared definitions for the beep pattern generator: FSM state encoding and
// the default clock-cycles-per-millisecond for a 50 MHz clk.
package beep_sequencer_pkg;

  localparam int DEF_CLK_PER_MS = 50000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/beep_sequencer_ms_tick.sv
// beep_sequencer_ms_tick
// Millisecond prescaler. Counts 0..CLK_PER_MS-1 while running and flags the
// last count as a one-cycle tick, then wraps.
// Ports:
//   clk     system clock, rising edge
//   n_rst   asynchronous active-low reset
//   i_clr   synchronous clear (wins over i_run)
//   i_run   count enable
//   o_tick  high on the last cycle of each millisecond while running
module beep_sequencer_ms_tick #(
  parameter int CLK_PER_MS = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clr,
  input  logic i_run,
  output logic o_tick
);

  localparam int CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_MS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_LAST);
  // Tick is not gated by i_clr: the clear is derived from the tick-driven
  // state change, so gating here would form a combinational loop.
  assign o_tick = i_run & w_last;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      if (w_last) r_cnt <= '0;
      else        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/beep_sequencer.sv
// beep_sequencer
// Drives the buzzer tone stage enable with N beeps of programmable ON/OFF
// length in milliseconds, reporting progress via busy/done.
// Ports:
//   clk, n_rst       system clock / asynchronous active-low reset
//   i_start          1-cycle request, sampled only in IDLE
//   i_n_beeps        beep count, latched on accepted start
//   i_on_ms          ON length in ms, latched on accepted start
//   i_off_ms         gap length in ms (0 behaves as 1), latched on accepted start
//   i_abort          synchronous cancel, highest priority
//   o_beep_en        high during ON phases (tone stage enable)
//   o_busy           high whenever not IDLE
//   o_done           1-cycle pulse on normal completion
//
// state  | meaning
// IDLE   | waiting for start
// ON     | beep_en high, timing on_ms
// OFF    | gap between beeps, timing off_ms (min 1 ms)
// DONE   | single cycle, done pulse
module beep_sequencer
  import beep_sequencer_pkg::*;
#(
  parameter int CLK_PER_MS = DEF_CLK_PER_MS,
  parameter int MS_W       = 10,
  parameter int NB_W       = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            i_start,
  input  logic [NB_W-1:0] i_n_beeps,
  input  logic [MS_W-1:0] i_on_ms,
  input  logic [MS_W-1:0] i_off_ms,
  input  logic            i_abort,
  output logic            o_beep_en,
  output logic            o_busy,
  output logic            o_done
);

  localparam logic [NB_W-1:0] REM_ONE = NB_W'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MS_W-1:0] r_on_ms;
  logic [MS_W-1:0] r_off_ms;
  logic [MS_W-1:0] r_ms_cnt;
  logic [NB_W-1:0] r_rem;
  logic            r_beep_en;
  logic            r_busy;
  logic            r_done;

  logic            w_tick;
  logic            w_run;
  logic            w_clr;
  logic            w_accept;
  logic            w_phase_end;
  logic [MS_W-1:0] w_len_last;

  assign w_run    = (r_state == S_ON) || (r_state == S_OFF);
  // Clearing on every state change keeps each phase aligned to a ms boundary.
  assign w_clr    = (w_state_nxt != r_state);
  assign w_accept = (r_state == S_IDLE) && i_start && !i_abort;

  beep_sequencer_ms_tick #(
    .CLK_PER_MS (CLK_PER_MS)
  ) u_ms_tick (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_clr  (w_clr),
    .i_run  (w_run),
    .o_tick (w_tick)
  );

  always_comb begin
    w_len_last = '0;
    if (r_state == S_ON)         w_len_last = r_on_ms - 1'b1;
    else if (r_off_ms != '0)     w_len_last = r_off_ms - 1'b1;
    w_phase_end = w_tick && (r_ms_cnt == w_len_last);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if ((i_n_beeps == '0) || (i_on_ms == '0)) w_state_nxt = S_DONE;
          else                                      w_state_nxt = S_ON;
        end
      end
      S_ON: begin
        if (w_phase_end) w_state_nxt = (r_rem == REM_ONE) ? S_DONE : S_OFF;
      end
      S_OFF: begin
        if (w_phase_end) w_state_nxt = S_ON;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_on_ms   <= '0;
      r_off_ms  <= '0;
      r_ms_cnt  <= '0;
      r_rem     <= '0;
      r_beep_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_beep_en <= (w_state_nxt == S_ON);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);

      if (w_accept) begin
        r_on_ms  <= i_on_ms;
        r_off_ms <= i_off_ms;
      end

      if (w_clr)       r_ms_cnt <= '0;
      else if (w_tick) r_ms_cnt <= r_ms_cnt + 1'b1;

      if (i_abort)                           r_rem <= '0;
      else if (w_accept)                     r_rem <= i_n_beeps;
      else if ((r_state == S_ON) && w_phase_end) r_rem <= r_rem - 1'b1;
    end
  end

  assign o_beep_en = r_beep_en;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_beep_sequencer.sv
// tb_beep_sequencer
// Directed bench for beep_sequencer at CLK_PER_MS=4. Cycle index k counts
// clock edges after the edge that sampled start (k=1 is the first cycle of
// the response); outputs are sampled 1 time unit after each rising edge.
module tb_beep_sequencer;

  localparam int CPM  = 4;
  localparam int MS_W = 10;
  localparam int NB_W = 4;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            i_start;
  logic [NB_W-1:0] i_n_beeps;
  logic [MS_W-1:0] i_on_ms;
  logic [MS_W-1:0] i_off_ms;
  logic            i_abort;
  logic            o_beep_en;
  logic            o_busy;
  logic            o_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  beep_sequencer #(
    .CLK_PER_MS (CPM),
    .MS_W       (MS_W),
    .NB_W       (NB_W)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_start   (i_start),
    .i_n_beeps (i_n_beeps),
    .i_on_ms   (i_on_ms),
    .i_off_ms  (i_off_ms),
    .i_abort   (i_abort),
    .o_beep_en (o_beep_en),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int k,
                          input logic e_beep, input logic e_busy, input logic e_done);
    chk($sformatf("%s beep_en k=%0d", tag, k), o_beep_en, e_beep);
    chk($sformatf("%s busy k=%0d",    tag, k), o_busy,    e_busy);
    chk($sformatf("%s done k=%0d",    tag, k), o_done,    e_done);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int nb, input int on, input int off);
    i_n_beeps = NB_W'(nb);
    i_on_ms   = MS_W'(on);
    i_off_ms  = MS_W'(off);
    i_start   = 1'b1;
  endtask

  // Issue start and advance to k=1.
  task automatic start_req(input int nb, input int on, input int off);
    set_req(nb, on, off);
    step();
    i_start = 1'b0;
  endtask

  // n=2, on=3 ms, off=2 ms: ON k1..12, OFF k13..20, ON k21..32, DONE k33.
  // With repulse, extra starts land during ON (k=5) and DONE (k=33).
  task automatic run_two_beeps(input string tag, input bit repulse);
    start_req(2, 3, 2);
    for (int k = 1; k <= 36; k++) begin
      chk_outs(tag, k, ((k >= 1 && k <= 12) || (k >= 21 && k <= 32)),
               (k <= 33), (k == 33));
      if (repulse && (k == 5 || k == 33)) set_req(5, 1, 1);
      else                                i_start = 1'b0;
      step();
    end
    i_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_rst     = 1'b0;
    i_start   = 1'b0;
    i_abort   = 1'b0;
    i_n_beeps = '0;
    i_on_ms   = '0;
    i_off_ms  = '0;
    #12;
    chk_outs("reset", 0, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b1;
    step();
    step();
    chk_outs("idle_after_reset", 0, 1'b0, 1'b0, 1'b0);

    run_two_beeps("two_beeps", 1'b0);

    // zero beep count and zero on-length both skip straight to DONE
    start_req(0, 3, 2);
    chk_outs("nb0", 1, 1'b0, 1'b1, 1'b1);
    step();
    chk_outs("nb0", 2, 1'b0, 1'b0, 1'b0);
    step();
    start_req(2, 0, 2);
    chk_outs("on0", 1, 1'b0, 1'b1, 1'b1);
    step();
    chk_outs("on0", 2, 1'b0, 1'b0, 1'b0);
    step();

    // n=3, on=1 ms, off=0 (as 1 ms): ON 1..4, 9..12, 17..20; DONE 21
    start_req(3, 1, 0);
    for (int k = 1; k <= 24; k++) begin
      chk_outs("three_short", k,
               ((k >= 1 && k <= 4) || (k >= 9 && k <= 12) || (k >= 17 && k <= 20)),
               (k <= 21), (k == 21));
      step();
    end

    // abort during the 6th cycle of ON
    start_req(2, 3, 2);
    for (int k = 1; k <= 6; k++) begin
      chk_outs("abort_pre", k, 1'b1, 1'b1, 1'b0);
      if (k == 6) i_abort = 1'b1;
      step();
    end
    i_abort = 1'b0;
    for (int k = 7; k <= 12; k++) begin
      chk_outs("abort_post", k, 1'b0, 1'b0, 1'b0);
      step();
    end
    start_req(1, 1, 1);
    for (int k = 1; k <= 7; k++) begin
      chk_outs("after_abort", k, (k <= 4), (k <= 5), (k == 5));
      step();
    end

    // start together with abort in IDLE is dropped
    set_req(2, 3, 2);
    i_abort = 1'b1;
    step();
    i_start = 1'b0;
    i_abort = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk_outs("start_abort_idle", k, 1'b0, 1'b0, 1'b0);
      step();
    end

    run_two_beeps("repulse", 1'b1);

    // asynchronous reset in the middle of ON
    start_req(3, 3, 2);
    step();
    step();
    chk_outs("pre_rst", 3, 1'b1, 1'b1, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    chk_outs("async_rst", 3, 1'b0, 1'b0, 1'b0);
    #2;
    n_rst = 1'b1;
    step();
    for (int k = 1; k <= 10; k++) begin
      chk_outs("post_rst", k, 1'b0, 1'b0, 1'b0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
